// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared types and constants for the Y86-64 pipeline register
//                bank: per-stage packed structs, status/icode/register-ID
//                constants and functions returning each stage's nop bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Data path width of every value field carried in the stage structs.
    localparam int DATA_W = 64;

    // Instruction and register-ID encodings used by the bubble values.
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    // Pipeline status codes.
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    // Decode register contents (147 bits).
    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        rA;
        logic [3:0]        rB;
        logic [DATA_W-1:0] valC;
        logic [DATA_W-1:0] valP;
    } dreg_t;

    // Execute register contents (219 bits).
    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] valC;
        logic [DATA_W-1:0] valA;
        logic [DATA_W-1:0] valB;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
        logic [3:0]        srcA;
        logic [3:0]        srcB;
    } ereg_t;

    // Memory register contents (144 bits).
    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic              Cnd;
        logic [DATA_W-1:0] valE;
        logic [DATA_W-1:0] valA;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
    } mreg_t;

    // Write-back register contents (143 bits).
    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [DATA_W-1:0] valE;
        logic [DATA_W-1:0] valM;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
    } wreg_t;

    // A bubble is a well-formed nop: status OK, no register written or read,
    // every data field zero.
    function automatic dreg_t dreg_bubble();
        dreg_t b;
        b       = '0;
        b.stat  = SAOK;
        b.icode = INOP;
        b.rA    = RNONE;
        b.rB    = RNONE;
        return b;
    endfunction

    function automatic ereg_t ereg_bubble();
        ereg_t b;
        b       = '0;
        b.stat  = SAOK;
        b.icode = INOP;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        b.srcA  = RNONE;
        b.srcB  = RNONE;
        return b;
    endfunction

    function automatic mreg_t mreg_bubble();
        mreg_t b;
        b       = '0;
        b.stat  = SAOK;
        b.icode = INOP;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        return b;
    endfunction

    function automatic wreg_t wreg_bubble();
        wreg_t b;
        b       = '0;
        b.stat  = SAOK;
        b.icode = INOP;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        return b;
    endfunction

endpackage : y86_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : One pipeline register with reset > bubble > stall > load
//                priority and a sticky flag recording any cycle where stall
//                and bubble were requested together.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             bubble_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             conflict_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             conflict_q;
    logic             conflict_d;

    // Resolve bubble/stall/load; a bubble overrides a simultaneous stall.
    always_comb begin
        data_d     = data_q;
        conflict_d = conflict_q | (stall_i & bubble_i);
        if (bubble_i) begin
            data_d = BUBBLE;
        end else if (!stall_i) begin
            data_d = data_i;
        end
    end

    // Register state; reset restores the bubble and clears the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= BUBBLE;
            conflict_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            conflict_q <= conflict_d;
        end
    end

    assign data_o     = data_q;
    assign conflict_o = conflict_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: rtl/y86_pipe_regs.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pipe_regs
//  Description : F/D/E/M/W pipeline register bank for the pipelined Y86-64
//                core. Applies the hazard unit's per-stage stall/bubble
//                controls, records illegal stall+bubble combinations and
//                keeps saturating stall/bubble statistics.
//                The stage structs carry fixed 64-bit data fields; W_DATA
//                sizes the predicted-PC (F) register.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_pipe_regs
    import y86_pkg::*;
#(
    parameter int W_DATA = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_stall,
    input  logic              f_bubble,
    input  logic              d_stall,
    input  logic              d_bubble,
    input  logic              e_stall,
    input  logic              e_bubble,
    input  logic              m_stall,
    input  logic              m_bubble,
    input  logic              w_stall,
    input  logic              w_bubble,
    input  logic [W_DATA-1:0] f_in,
    input  dreg_t             d_in,
    input  ereg_t             e_in,
    input  mreg_t             m_in,
    input  wreg_t             w_in,
    output logic [W_DATA-1:0] F_q,
    output dreg_t             D_q,
    output ereg_t             E_q,
    output mreg_t             M_q,
    output wreg_t             W_q,
    output logic              cpu_halt,
    output logic [4:0]        ctl_conflict,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam int D_W = $bits(dreg_t);
    localparam int E_W = $bits(ereg_t);
    localparam int M_W = $bits(mreg_t);
    localparam int W_W = $bits(wreg_t);

    logic [D_W-1:0] d_q_bits;
    logic [E_W-1:0] e_q_bits;
    logic [M_W-1:0] m_q_bits;
    logic [W_W-1:0] w_q_bits;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic             any_stall;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    pipe_stage_reg #(
        .WIDTH  (W_DATA),
        .BUBBLE ('0)
    ) u_freg (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (f_stall),
        .bubble_i   (f_bubble),
        .data_i     (f_in),
        .data_o     (F_q),
        .conflict_o (ctl_conflict[0])
    );

    pipe_stage_reg #(
        .WIDTH  (D_W),
        .BUBBLE (dreg_bubble())
    ) u_dreg (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (d_stall),
        .bubble_i   (d_bubble),
        .data_i     (d_in),
        .data_o     (d_q_bits),
        .conflict_o (ctl_conflict[1])
    );

    pipe_stage_reg #(
        .WIDTH  (E_W),
        .BUBBLE (ereg_bubble())
    ) u_ereg (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (e_stall),
        .bubble_i   (e_bubble),
        .data_i     (e_in),
        .data_o     (e_q_bits),
        .conflict_o (ctl_conflict[2])
    );

    pipe_stage_reg #(
        .WIDTH  (M_W),
        .BUBBLE (mreg_bubble())
    ) u_mreg (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (m_stall),
        .bubble_i   (m_bubble),
        .data_i     (m_in),
        .data_o     (m_q_bits),
        .conflict_o (ctl_conflict[3])
    );

    pipe_stage_reg #(
        .WIDTH  (W_W),
        .BUBBLE (wreg_bubble())
    ) u_wreg (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (w_stall),
        .bubble_i   (w_bubble),
        .data_i     (w_in),
        .data_o     (w_q_bits),
        .conflict_o (ctl_conflict[4])
    );

    assign D_q = dreg_t'(d_q_bits);
    assign E_q = ereg_t'(e_q_bits);
    assign M_q = mreg_t'(m_q_bits);
    assign W_q = wreg_t'(w_q_bits);

    // Any non-OK status reaching write-back halts the core.
    assign cpu_halt = (W_q.stat != SAOK);

    // ------------------------------------------------------------------
    // Statistics: count the raw controls, not the resolved actions
    // ------------------------------------------------------------------
    assign any_stall = f_stall | d_stall | e_stall | m_stall | w_stall;

    // Saturating next-count for both statistics counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (any_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (e_bubble && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    // Counter registers; reset clears them on the same edge it applies.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule : y86_pipe_regs
`default_nettype wire

// File: tb/tb_y86_pipe_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y86_pipe_regs
//  Description : Directed self-checking bench for y86_pipe_regs (CNT_W = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_pipe_regs;
    import y86_pkg::*;

    localparam int W_DATA = 64;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              f_stall, f_bubble, d_stall, d_bubble, e_stall, e_bubble;
    logic              m_stall, m_bubble, w_stall, w_bubble;
    logic [W_DATA-1:0] f_in;
    dreg_t             d_in;
    ereg_t             e_in;
    mreg_t             m_in;
    wreg_t             w_in;
    logic [W_DATA-1:0] F_q;
    dreg_t             D_q;
    ereg_t             E_q;
    mreg_t             M_q;
    wreg_t             W_q;
    logic              cpu_halt;
    logic [4:0]        ctl_conflict;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks = 0;
    int errors = 0;

    dreg_t             d_nop, d_exp;
    ereg_t             e_nop;
    mreg_t             m_nop;
    wreg_t             w_nop, w_exp;
    logic [W_DATA-1:0] f_exp;
    logic [3:0]        icode_seq [3];

    y86_pipe_regs #(
        .W_DATA (W_DATA),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .f_stall      (f_stall),
        .f_bubble     (f_bubble),
        .d_stall      (d_stall),
        .d_bubble     (d_bubble),
        .e_stall      (e_stall),
        .e_bubble     (e_bubble),
        .m_stall      (m_stall),
        .m_bubble     (m_bubble),
        .w_stall      (w_stall),
        .w_bubble     (w_bubble),
        .f_in         (f_in),
        .d_in         (d_in),
        .e_in         (e_in),
        .m_in         (m_in),
        .w_in         (w_in),
        .F_q          (F_q),
        .D_q          (D_q),
        .E_q          (E_q),
        .M_q          (M_q),
        .W_q          (W_q),
        .cpu_halt     (cpu_halt),
        .ctl_conflict (ctl_conflict),
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point: count it, report any mismatch.
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // Fresh random stage inputs; write-back status kept OK unless overridden.
    task automatic rand_inputs();
        f_in = r64();
        d_in = '{stat: 3'($urandom), icode: 4'($urandom), ifun: 4'($urandom),
                 rA: 4'($urandom), rB: 4'($urandom), valC: r64(), valP: r64()};
        e_in = '{stat: 3'($urandom), icode: 4'($urandom), ifun: 4'($urandom),
                 valC: r64(), valA: r64(), valB: r64(), dstE: 4'($urandom),
                 dstM: 4'($urandom), srcA: 4'($urandom), srcB: 4'($urandom)};
        m_in = '{stat: 3'($urandom), icode: 4'($urandom), Cnd: 1'($urandom),
                 valE: r64(), valA: r64(), dstE: 4'($urandom), dstM: 4'($urandom)};
        w_in = '{stat: SAOK, icode: 4'($urandom), valE: r64(), valM: r64(),
                 dstE: 4'($urandom), dstM: 4'($urandom)};
    endtask

    // Controls in {W,M,E,D,F} order.
    task automatic set_ctl(input logic [4:0] st, input logic [4:0] bu);
        {w_stall, m_stall, e_stall, d_stall, f_stall}      = st;
        {w_bubble, m_bubble, e_bubble, d_bubble, f_bubble} = bu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d_nop = '0; d_nop.stat = 3'd1; d_nop.icode = 4'h1; d_nop.rA = 4'hF; d_nop.rB = 4'hF;
        e_nop = '0; e_nop.stat = 3'd1; e_nop.icode = 4'h1;
        e_nop.dstE = 4'hF; e_nop.dstM = 4'hF; e_nop.srcA = 4'hF; e_nop.srcB = 4'hF;
        m_nop = '0; m_nop.stat = 3'd1; m_nop.icode = 4'h1; m_nop.dstE = 4'hF; m_nop.dstM = 4'hF;
        w_nop = '0; w_nop.stat = 3'd1; w_nop.icode = 4'h1; w_nop.dstE = 4'hF; w_nop.dstM = 4'hF;
        icode_seq[0] = 4'd3; icode_seq[1] = 4'd6; icode_seq[2] = 4'd2;

        // Reset with random inputs and controls.
        reset = 1'b1;
        rand_inputs();
        w_in.stat = SHLT;
        set_ctl(5'($urandom), 5'($urandom));
        step();
        check("rst_D", 256'(D_q), 256'(d_nop));
        check("rst_E", 256'(E_q), 256'(e_nop));
        check("rst_M", 256'(M_q), 256'(m_nop));
        check("rst_W", 256'(W_q), 256'(w_nop));
        check("rst_F", 256'(F_q), 256'(0));
        check("rst_stall_cnt", 256'(stall_cnt), 256'(0));
        check("rst_bubble_cnt", 256'(bubble_cnt), 256'(0));
        check("rst_conflict", 256'(ctl_conflict), 256'(0));
        check("rst_halt", 256'(cpu_halt), 256'(0));

        // Free run: every stage loads one cycle later.
        reset = 1'b0;
        set_ctl(5'b00000, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            d_in.icode = icode_seq[i];
            step();
            check("run_D", 256'(D_q), 256'(d_in));
            check("run_D_icode", 256'(D_q.icode), 256'(icode_seq[i]));
            check("run_E", 256'(E_q), 256'(e_in));
            check("run_F", 256'(F_q), 256'(f_in));
            check("run_W", 256'(W_q), 256'(w_in));
        end
        check("run_conflict", 256'(ctl_conflict), 256'(0));
        check("run_stall_cnt", 256'(stall_cnt), 256'(0));
        check("run_halt", 256'(cpu_halt), 256'(0));

        // Load/use: F and D hold, E gets a nop.
        d_exp = d_in;
        f_exp = f_in;
        rand_inputs();
        set_ctl(5'b00011, 5'b00100);
        step();
        check("lu_D_hold", 256'(D_q), 256'(d_exp));
        check("lu_F_hold", 256'(F_q), 256'(f_exp));
        check("lu_E_nop", 256'(E_q), 256'(e_nop));
        check("lu_M_load", 256'(M_q), 256'(m_in));
        check("lu_stall_cnt", 256'(stall_cnt), 256'(1));
        check("lu_bubble_cnt", 256'(bubble_cnt), 256'(1));
        set_ctl(5'b00000, 5'b00000);
        step();
        check("lu_D_release", 256'(D_q), 256'(d_in));
        check("lu_F_release", 256'(F_q), 256'(f_in));
        check("lu_E_release", 256'(E_q), 256'(e_in));

        // Mispredict: D and E bubbled, M loads.
        rand_inputs();
        set_ctl(5'b00000, 5'b00110);
        step();
        check("mp_D_nop", 256'(D_q), 256'(d_nop));
        check("mp_E_nop", 256'(E_q), 256'(e_nop));
        check("mp_M_load", 256'(M_q), 256'(m_in));
        check("mp_bubble_cnt", 256'(bubble_cnt), 256'(2));
        check("mp_stall_cnt", 256'(stall_cnt), 256'(1));

        // Illegal stall+bubble on D: bubble wins, sticky flag set.
        rand_inputs();
        set_ctl(5'b00010, 5'b00010);
        step();
        check("cf_D_nop", 256'(D_q), 256'(d_nop));
        check("cf_flag", 256'(ctl_conflict), 256'(5'b00010));
        check("cf_stall_cnt", 256'(stall_cnt), 256'(2));
        set_ctl(5'b00000, 5'b00000);
        step();
        step();
        check("cf_sticky", 256'(ctl_conflict), 256'(5'b00010));
        check("cf_D_load", 256'(D_q), 256'(d_in));

        // W stall holds write-back contents.
        w_exp = w_in;
        rand_inputs();
        set_ctl(5'b10000, 5'b00000);
        step();
        check("ws_W_hold", 256'(W_q), 256'(w_exp));
        check("ws_stall_cnt", 256'(stall_cnt), 256'(3));

        // Reset mid-operation overrides controls and clears statistics.
        reset = 1'b1;
        set_ctl(5'b00010, 5'b00100);
        step();
        check("mr_D_nop", 256'(D_q), 256'(d_nop));
        check("mr_E_nop", 256'(E_q), 256'(e_nop));
        check("mr_conflict", 256'(ctl_conflict), 256'(0));
        check("mr_stall_cnt", 256'(stall_cnt), 256'(0));
        check("mr_bubble_cnt", 256'(bubble_cnt), 256'(0));
        reset = 1'b0;

        // Saturation: 20 stalled cycles on a 4-bit counter.
        set_ctl(5'b00001, 5'b00000);
        for (int i = 0; i < 20; i++) begin
            f_in = r64();
            step();
            if (i == 14) check("sat_stall_15", 256'(stall_cnt), 256'(15));
        end
        check("sat_stall_cnt", 256'(stall_cnt), 256'(15));
        check("sat_F_frozen", 256'(F_q), 256'(0));
        set_ctl(5'b00000, 5'b00100);
        for (int i = 0; i < 20; i++) step();
        check("sat_bubble_cnt", 256'(bubble_cnt), 256'(15));
        check("sat_stall_kept", 256'(stall_cnt), 256'(15));

        // Halt status reaching W raises cpu_halt after the edge.
        set_ctl(5'b00000, 5'b00000);
        rand_inputs();
        check("halt_before", 256'(cpu_halt), 256'(0));
        w_in.stat = SHLT;
        step();
        check("halt_after", 256'(cpu_halt), 256'(1));
        check("halt_W", 256'(W_q), 256'(w_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_y86_pipe_regs
`default_nettype wire
